// File: rtl/rdout_pkg.sv
// Shared definitions for the readout FIFO arbiter: FSM encoding and the
// source-id / output width helpers used by the top-level port list.
package rdout_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } arb_state_t;

  localparam int BURST_CNT_W = 8;

  // A single source still carries a 1-bit id so the output format is fixed.
  function automatic int src_id_width(input int num_src);
    return (num_src > 2) ? $clog2(num_src) : 1;
  endfunction

  function automatic int out_width(input int data_w, input int num_src);
    return data_w + src_id_width(num_src);
  endfunction

endpackage

// File: rtl/rdout_src_buf.sv
// Per-source first-word-fall-through buffer: depth 2**AW, full/almost-full/empty
// flags from the pointer difference, and a sticky flag for dropped pushes.
module rdout_src_buf #(
  parameter int DATA_W = 32,
  parameter int AW     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              almst_full,
  output logic              empty,
  output logic              last,
  output logic              ovf
);

  localparam int CW    = AW + 1;
  localparam int DEPTH = 1 << AW;

  logic [CW-1:0]     wr_ptr;
  logic [CW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              push;

  assign count      = wr_ptr - rd_ptr;
  assign full       = (count == CW'(DEPTH));
  assign almst_full = (count >= CW'(DEPTH - 1));
  assign empty      = (count == '0);
  // Full is judged on the registered count, so a push on a full buffer is
  // dropped even when the same cycle pops.
  assign push       = wr && !full;
  assign rd_data    = mem[rd_ptr[AW-1:0]];
  assign last       = rd && !push && (count == CW'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (rd && !empty) rd_ptr <= rd_ptr + 1'b1;
      if (wr && full) ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/rdout_fifo_arb.sv
// Round-robin arbiter draining per-source buffers in bounded bursts into one
// shared readout FIFO, tagging each word with its source index.
module rdout_fifo_arb import rdout_pkg::*; #(
  parameter int NUM_SRC_G       = 2,
  parameter int READOUT_WIDTH_G = 32,
  parameter int BUF_AW_G        = 2,
  parameter int BURST_G         = 8,
  localparam int SRC_ID_W_C     = src_id_width(NUM_SRC_G),
  localparam int OUT_WIDTH_C    = out_width(READOUT_WIDTH_G, NUM_SRC_G)
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [NUM_SRC_G-1:0]                 src_wr_i,
  input  logic [NUM_SRC_G*READOUT_WIDTH_G-1:0] src_data_i,
  output logic [NUM_SRC_G-1:0]                 src_full_o,
  output logic [NUM_SRC_G-1:0]                 src_almst_full_o,
  output logic [NUM_SRC_G-1:0]                 src_ovf_o,
  input  logic                                 fifo_full_i,
  input  logic                                 fifo_almst_full_i,
  output logic                                 fifo_wr_o,
  output logic [OUT_WIDTH_C-1:0]               fifo_data_o,
  output logic [NUM_SRC_G-1:0]                 grant_o,
  output logic                                 fifo_drop_o
);

  localparam logic [SRC_ID_W_C-1:0]  LAST_ID    = SRC_ID_W_C'(NUM_SRC_G - 1);
  localparam logic [BURST_CNT_W-1:0] BURST_MAX  = BURST_CNT_W'(BURST_G);
  localparam logic [BURST_CNT_W-1:0] BURST_LAST = BURST_CNT_W'(BURST_G - 1);

  arb_state_t                 state;
  arb_state_t                 state_nxt;
  logic [SRC_ID_W_C-1:0]      rr_ptr;
  logic [SRC_ID_W_C-1:0]      gnt_idx;
  logic [SRC_ID_W_C-1:0]      sel_idx;
  logic [SRC_ID_W_C-1:0]      scan_idx;
  logic                       sel_vld;
  logic                       arb_go;
  logic                       can_pop;
  logic [BURST_CNT_W-1:0]     burst_cnt;
  logic [NUM_SRC_G-1:0]       empty;
  logic [NUM_SRC_G-1:0]       last;
  logic [NUM_SRC_G-1:0]       pop;
  logic [READOUT_WIDTH_G-1:0] buf_data [NUM_SRC_G];

  for (genvar i = 0; i < NUM_SRC_G; i++) begin : g_src
    rdout_src_buf #(
      .DATA_W(READOUT_WIDTH_G),
      .AW    (BUF_AW_G)
    ) u_buf (
      .clk       (clk_i),
      .rst       (rst_i),
      .wr        (src_wr_i[i]),
      .wr_data   (src_data_i[i*READOUT_WIDTH_G +: READOUT_WIDTH_G]),
      .rd        (pop[i]),
      .rd_data   (buf_data[i]),
      .full      (src_full_o[i]),
      .almst_full(src_almst_full_o[i]),
      .empty     (empty[i]),
      .last      (last[i]),
      .ovf       (src_ovf_o[i])
    );
  end

  // Scan rr_ptr+1, rr_ptr+2, ... (mod NUM_SRC_G) for the first non-empty buffer.
  always_comb begin
    sel_vld  = 1'b0;
    sel_idx  = '0;
    scan_idx = rr_ptr;
    for (int k = 0; k < NUM_SRC_G; k++) begin
      scan_idx = (scan_idx == LAST_ID) ? '0 : scan_idx + 1'b1;
      if (!sel_vld && !empty[scan_idx]) begin
        sel_vld = 1'b1;
        sel_idx = scan_idx;
      end
    end
  end

  assign can_pop = (state == XFER) && !fifo_almst_full_i && !empty[gnt_idx];

  always_comb begin
    pop = '0;
    if (can_pop) pop[gnt_idx] = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    arb_go    = 1'b0;
    grant_o   = '0;
    case (state)
      IDLE: begin
        if (sel_vld && !fifo_almst_full_i) begin
          arb_go           = 1'b1;
          grant_o[sel_idx] = 1'b1;
          state_nxt        = XFER;
        end
      end
      XFER: begin
        grant_o[gnt_idx] = 1'b1;
        if (can_pop && (last[gnt_idx] || burst_cnt == BURST_LAST)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  // Output register stage: one tagged word per popped cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr      <= LAST_ID;
      gnt_idx     <= '0;
      burst_cnt   <= '0;
      fifo_wr_o   <= 1'b0;
      fifo_data_o <= '0;
      fifo_drop_o <= 1'b0;
    end else begin
      fifo_wr_o <= can_pop;
      if (can_pop) fifo_data_o <= {gnt_idx, buf_data[gnt_idx]};
      if (arb_go) begin
        gnt_idx   <= sel_idx;
        rr_ptr    <= sel_idx;
        burst_cnt <= '0;
      end else if (can_pop && burst_cnt < BURST_MAX) begin
        burst_cnt <= burst_cnt + 1'b1;
      end
      if (fifo_wr_o && fifo_full_i) fifo_drop_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rdout_fifo_arb.sv
// Bench for rdout_fifo_arb: directed table, hand-written corner sequences and
// random traffic, all checked every cycle against a queue-based reference model.
module tb_rdout_fifo_arb;

  localparam int NS    = 2;
  localparam int W     = 32;
  localparam int AW    = 2;
  localparam int DEPTH = 4;
  localparam int BURST = 2;
  localparam int IDW   = 1;
  localparam int OW    = W + IDW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [NS-1:0]   src_wr;
  logic [NS*W-1:0] src_data;
  logic            fifo_full;
  logic            fifo_almst;
  logic [NS-1:0]   src_full;
  logic [NS-1:0]   src_almst;
  logic [NS-1:0]   src_ovf;
  logic            fifo_wr;
  logic [OW-1:0]   fifo_data;
  logic [NS-1:0]   grant;
  logic            fifo_drop;

  rdout_fifo_arb #(
    .NUM_SRC_G      (NS),
    .READOUT_WIDTH_G(W),
    .BUF_AW_G       (AW),
    .BURST_G        (BURST)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .src_wr_i         (src_wr),
    .src_data_i       (src_data),
    .src_full_o       (src_full),
    .src_almst_full_o (src_almst),
    .src_ovf_o        (src_ovf),
    .fifo_full_i      (fifo_full),
    .fifo_almst_full_i(fifo_almst),
    .fifo_wr_o        (fifo_wr),
    .fifo_data_o      (fifo_data),
    .grant_o          (grant),
    .fifo_drop_o      (fifo_drop)
  );

  int vecs = 0;
  int errs = 0;

  // Reference model state: one queue per source plus the burst bookkeeping.
  logic [W-1:0]  mq [NS][$];
  bit            m_busy = 1'b0;
  int            m_src  = 0;
  int            m_cnt  = 0;
  int            m_rr   = NS - 1;
  bit            m_wr   = 1'b0;
  logic [OW-1:0] m_data = '0;
  logic [NS-1:0] m_ovf  = '0;
  bit            m_drop = 1'b0;
  logic [OW-1:0] got [$];

  typedef struct {
    bit            rst;
    logic [NS-1:0] wr;
    logic [W-1:0]  d0;
    logic          exp_wr;
    logic [OW-1:0] exp_data;
    logic [NS-1:0] exp_grant;
  } vec_t;
  vec_t tbl [6];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      if (errs <= 40) $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int pick_src();
    for (int k = 1; k <= NS; k++)
      if (mq[(m_rr + k) % NS].size() > 0) return (m_rr + k) % NS;
    return -1;
  endfunction

  function automatic logic [NS-1:0] exp_grant();
    logic [NS-1:0] g;
    int p;
    g = '0;
    if (m_busy) g[m_src] = 1'b1;
    else begin
      p = pick_src();
      if (!fifo_almst && p >= 0) g[p] = 1'b1;
    end
    return g;
  endfunction

  task automatic model_step();
    bit acc [NS];
    int p;
    if (rst) begin
      for (int i = 0; i < NS; i++) mq[i].delete();
      m_busy = 1'b0; m_src = 0; m_cnt = 0; m_rr = NS - 1;
      m_wr = 1'b0; m_data = '0; m_ovf = '0; m_drop = 1'b0;
      return;
    end
    if (m_wr && fifo_full) m_drop = 1'b1;
    for (int i = 0; i < NS; i++) begin
      acc[i] = src_wr[i] && (mq[i].size() < DEPTH);
      if (src_wr[i] && !acc[i]) m_ovf[i] = 1'b1;
    end
    m_wr = 1'b0;
    if (!m_busy) begin
      p = pick_src();
      if (!fifo_almst && p >= 0) begin
        m_busy = 1'b1; m_src = p; m_rr = p; m_cnt = 0;
      end
    end else if (!fifo_almst && mq[m_src].size() > 0) begin
      if (mq[m_src].size() == 1 && !acc[m_src]) m_busy = 1'b0;
      m_data = {IDW'(m_src), mq[m_src].pop_front()};
      m_wr   = 1'b1;
      m_cnt++;
      if (m_cnt == BURST) m_busy = 1'b0;
    end
    for (int i = 0; i < NS; i++)
      if (acc[i]) mq[i].push_back(src_data[i*W +: W]);
  endtask

  task automatic compare_model();
    logic [NS-1:0] ef, ea;
    for (int i = 0; i < NS; i++) begin
      ef[i] = (mq[i].size() == DEPTH);
      ea[i] = (mq[i].size() >= DEPTH - 1);
    end
    chk("model_wr", fifo_wr, m_wr);
    chk("model_data", fifo_data, m_data);
    chk("model_grant", grant, exp_grant());
    chk("model_full", src_full, ef);
    chk("model_almst", src_almst, ea);
    chk("model_ovf", src_ovf, m_ovf);
    chk("model_drop", fifo_drop, m_drop);
  endtask

  task automatic step(input bit r, input logic [NS-1:0] w, input logic [W-1:0] d0,
                      input logic [W-1:0] d1, input bit af, input bit ff);
    rst = r; src_wr = w; src_data = {d1, d0}; fifo_almst = af; fifo_full = ff;
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_model();
    if (fifo_wr === 1'b1) got.push_back(fifo_data);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, n1;
    int t2_id [8] = '{0, 0, 1, 1, 0, 0, 1, 1};
    int t2_k  [8] = '{0, 1, 0, 1, 2, 3, 2, 3};
    logic [W-1:0] base;
    rst = 1'b1; src_wr = '0; src_data = '0; fifo_full = 1'b0; fifo_almst = 1'b0;
    @(negedge clk);

    // Single word: grant for two cycles, tagged word on the third.
    tbl[0] = '{rst: 1'b1, wr: 2'b00, d0: '0,           exp_wr: 1'b0, exp_data: '0,                 exp_grant: 2'b00};
    tbl[1] = '{rst: 1'b0, wr: 2'b00, d0: '0,           exp_wr: 1'b0, exp_data: '0,                 exp_grant: 2'b00};
    tbl[2] = '{rst: 1'b0, wr: 2'b01, d0: 32'hDEADBEEF, exp_wr: 1'b0, exp_data: '0,                 exp_grant: 2'b01};
    tbl[3] = '{rst: 1'b0, wr: 2'b00, d0: '0,           exp_wr: 1'b0, exp_data: '0,                 exp_grant: 2'b01};
    tbl[4] = '{rst: 1'b0, wr: 2'b00, d0: '0,           exp_wr: 1'b1, exp_data: {1'b0, 32'hDEADBEEF}, exp_grant: 2'b00};
    tbl[5] = '{rst: 1'b0, wr: 2'b00, d0: '0,           exp_wr: 1'b0, exp_data: '0,                 exp_grant: 2'b00};
    for (int i = 0; i < 6; i++) begin
      step(tbl[i].rst, tbl[i].wr, tbl[i].d0, '0, 1'b0, 1'b0);
      chk($sformatf("t1_wr[%0d]", i), fifo_wr, tbl[i].exp_wr);
      chk($sformatf("t1_grant[%0d]", i), grant, tbl[i].exp_grant);
      if (tbl[i].exp_wr || tbl[i].rst) chk($sformatf("t1_data[%0d]", i), fifo_data, tbl[i].exp_data);
      if (tbl[i].rst) begin
        chk("rst_full", src_full, 0);
        chk("rst_almst", src_almst, 0);
        chk("rst_ovf", src_ovf, 0);
        chk("rst_drop", fifo_drop, 0);
      end
    end

    // Both sources write four words together: bursts of BURST alternate.
    step(1'b1, '0, '0, '0, 1'b0, 1'b0);
    got.delete();
    for (int k = 0; k < 4; k++)
      step(1'b0, 2'b11, 32'hA000_0000 + k, 32'hB000_0000 + k, 1'b0, 1'b0);
    idle(14);
    chk("t2_count", got.size(), 8);
    for (int j = 0; j < 8 && j < got.size(); j++) begin
      base = (t2_id[j] == 0) ? 32'hA000_0000 : 32'hB000_0000;
      chk($sformatf("t2_word[%0d]", j), got[j], {IDW'(t2_id[j]), base + W'(t2_k[j])});
    end
    chk("t2_ovf", src_ovf, 0);

    // Both sources at half rate: neither may starve.
    step(1'b1, '0, '0, '0, 1'b0, 1'b0);
    got.delete();
    for (int c = 0; c < 600; c++)
      step(1'b0, (c % 2 == 0) ? 2'b11 : 2'b00, $urandom, $urandom, 1'b0, 1'b0);
    idle(20);
    n0 = 0; n1 = 0;
    foreach (got[j]) if (got[j][OW-1]) n1++; else n0++;
    chk("t3_src0_served", (n0 >= 150), 1);
    chk("t3_src1_served", (n1 >= 150), 1);

    // Random traffic with back-pressure, full flags and occasional reset.
    step(1'b1, '0, '0, '0, 1'b0, 1'b0);
    for (int c = 0; c < 800; c++)
      step(($urandom_range(0, 199) == 0), NS'($urandom_range(0, 3)) & NS'($urandom_range(0, 3)),
           $urandom, $urandom, ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0));

    // Stall mid-burst: grant held, buffer fills, fifth word overflows.
    step(1'b1, '0, '0, '0, 1'b0, 1'b0);
    got.delete();
    step(1'b0, 2'b01, 32'h40, '0, 1'b0, 1'b0);
    step(1'b0, 2'b01, 32'h41, '0, 1'b0, 1'b0);
    step(1'b0, 2'b00, '0, '0, 1'b0, 1'b0);
    for (int h = 0; h < 20; h++) begin
      step(1'b0, (h >= 1 && h <= 4) ? 2'b01 : 2'b00, 32'h41 + h, '0, 1'b1, 1'b0);
      chk($sformatf("t4_stall_wr[%0d]", h), fifo_wr, 0);
      chk($sformatf("t4_stall_grant[%0d]", h), grant, 2'b01);
    end
    chk("t4_full", src_full, 2'b01);
    chk("t4_ovf", src_ovf, 2'b01);
    idle(12);
    chk("t4_count", got.size(), 5);
    for (int j = 0; j < 5 && j < got.size(); j++)
      chk($sformatf("t4_word[%0d]", j), got[j], {1'b0, 32'h40 + j});

    // Shared FIFO full while a word is written: sticky drop flag.
    step(1'b1, '0, '0, '0, 1'b0, 1'b0);
    step(1'b0, 2'b10, '0, 32'h55, 1'b0, 1'b1);
    chk("t5_drop_before", fifo_drop, 0);
    for (int i = 0; i < 6; i++) step(1'b0, '0, '0, '0, 1'b0, 1'b1);
    chk("t5_drop_set", fifo_drop, 1);
    idle(5);
    chk("t5_drop_sticky", fifo_drop, 1);
    step(1'b1, '0, '0, '0, 1'b0, 1'b0);
    chk("t5_drop_cleared", fifo_drop, 0);

    // Reset during a burst with words still buffered.
    step(1'b0, 2'b01, 32'h60, '0, 1'b0, 1'b0);
    step(1'b0, 2'b01, 32'h61, '0, 1'b0, 1'b0);
    step(1'b0, 2'b01, 32'h62, '0, 1'b1, 1'b0);
    step(1'b0, 2'b01, 32'h63, '0, 1'b0, 1'b0);
    chk("t6_pre_wr", fifo_wr, 1);
    step(1'b1, '0, '0, '0, 1'b0, 1'b0);
    chk("t6_wr", fifo_wr, 0);
    chk("t6_data", fifo_data, 0);
    chk("t6_grant", grant, 0);
    chk("t6_full", src_full, 0);
    chk("t6_almst", src_almst, 0);
    chk("t6_ovf", src_ovf, 0);
    for (int i = 0; i < 10; i++) begin
      idle(1);
      chk($sformatf("t6_quiet_wr[%0d]", i), fifo_wr, 0);
      chk($sformatf("t6_quiet_grant[%0d]", i), grant, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
